// File: rtl/multicycle_ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle control unit.
//   state_t      - FSM state encoding (4 bits, exported on state_o)
//   OP_*         - instruction opcodes (IR[15:12])
//   ALUOP_*      - 2-bit ALU opcode handed to the ALU-control decoder
//   SRCB_*       - ALU B-operand mux selects
//   PCSRC_*      - PC source mux selects
//   ctrl_t       - bundle of Moore control outputs for one state
//   decode_state - state -> Moore control outputs
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_R_EXEC    = 4'd3,
        ST_R_WB      = 4'd4,
        ST_MEM_ADDR  = 4'd5,
        ST_MEM_RD    = 4'd6,
        ST_MEM_WB    = 4'd7,
        ST_MEM_WR    = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_ADDI_EXEC = 4'd10,
        ST_ADDI_WB   = 4'd11,
        ST_JUMP      = 4'd12,
        ST_HALT      = 4'd13
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b0001;
    localparam logic [3:0] OP_SW    = 4'b0010;
    localparam logic [3:0] OP_BEQ   = 4'b0011;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_J     = 4'b0101;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [1:0] ALUOP_FUNCT = 2'b00;
    localparam logic [1:0] ALUOP_ADD   = 2'b10;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFS = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       halted;
        logic       fetch;      // FETCH: ir_write/pc_write still need mem_ready
    } ctrl_t;

    function automatic ctrl_t decode_state(state_t s);
        ctrl_t c;
        c        = '0;
        c.alu_op = ALUOP_ADD;
        case (s)
            // IDLE only exists right after reset, so it matches the reset value.
            ST_IDLE:      c.alu_op = ALUOP_FUNCT;
            ST_FETCH: begin
                c.fetch     = 1'b1;
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_ONE;
                c.pc_source = PCSRC_ALU;
            end
            ST_DECODE:    c.alu_src_b = SRCB_BOFS;
            ST_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REGB;
                c.alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            ST_MEM_ADDR, ST_ADDI_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            ST_MEM_RD: begin
                c.mem_read = 1'b1;
                c.i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                c.mem_write = 1'b1;
                c.i_or_d    = 1'b1;
            end
            ST_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_REGB;
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
            end
            ST_ADDI_WB:   c.reg_write = 1'b1;
            ST_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_JUMP;
            end
            ST_HALT:      c.halted = 1'b1;
            default:      c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller <-> datapath/memory signal bundle.
//   Inputs to the controller : opcode[3:0], zero, mem_ready
//   Outputs of the controller: PC/memory/IR/register-file strobes and mux
//                              selects, alu_op, halted, bus_error, state_o
//   modport master : the control FSM
//   modport slave  : the datapath / memory side
interface multicycle_ctrl_if;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       halted;
    logic       bus_error;
    logic [3:0] state_o;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, halted, bus_error, state_o
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, halted, bus_error, state_o
    );
endinterface

// File: rtl/multicycle_ctrl_wait_timer.sv
// ctrl_wait_timer: counts consecutive cycles spent waiting on mem_ready.
//   clk, rst_n : clock, async active-low reset
//   clear      : FSM is entering a memory-access state this cycle
//   waiting    : FSM is in a memory-access state and mem_ready=0
//   expire     : this waiting cycle is the TIMEOUT-th in a row (0 if TIMEOUT=0)
module ctrl_wait_timer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic waiting,
    output logic expire
);
    localparam bit               ENABLED = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(ENABLED ? TIMEOUT - 1 : 0);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (waiting && ENABLED) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // mem_ready=1 drops 'waiting', so a completing access never expires.
    assign expire = ENABLED && waiting && (cnt == LAST);
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main multi-cycle control FSM of the 16-bit RISC core.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : multicycle_ctrl_if.master - opcode/zero/mem_ready in; all
//           datapath enables, mux selects, alu_op, halted, bus_error and
//           state_o out
// Moore outputs are registered from the next state, so they line up with
// the state register. ir_write/pc_write in FETCH are additionally gated
// combinationally by mem_ready.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input logic              clk,
    input logic              rst_n,
    multicycle_ctrl_if.master bus
);
    state_t state;
    state_t state_nxt;
    ctrl_t  ctrl_q;
    logic   bus_error_q;
    logic   wait_st;
    logic   enter_wait;
    logic   expire;

    assign wait_st = (state == ST_FETCH) || (state == ST_MEM_RD) || (state == ST_MEM_WR);

    // Counter restarts whenever a new memory access begins.
    assign enter_wait = (state_nxt != state) &&
                        ((state_nxt == ST_FETCH) || (state_nxt == ST_MEM_RD) ||
                         (state_nxt == ST_MEM_WR));

    ctrl_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (enter_wait),
        .waiting (wait_st && !bus.mem_ready),
        .expire  (expire)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (bus.mem_ready)  state_nxt = ST_DECODE;
                else if (expire)    state_nxt = ST_HALT;
            end
            ST_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     state_nxt = ST_R_EXEC;
                    OP_LW, OP_SW: state_nxt = ST_MEM_ADDR;
                    OP_BEQ:       state_nxt = ST_BRANCH;
                    OP_ADDI:      state_nxt = ST_ADDI_EXEC;
                    OP_J:         state_nxt = ST_JUMP;
                    default:      state_nxt = ST_HALT;   // OP_HALT and illegal
                endcase
            end
            ST_R_EXEC:    state_nxt = ST_R_WB;
            ST_R_WB:      state_nxt = ST_FETCH;
            ST_MEM_ADDR:  state_nxt = (bus.opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
                if (bus.mem_ready)  state_nxt = ST_MEM_WB;
                else if (expire)    state_nxt = ST_HALT;
            end
            ST_MEM_WB:    state_nxt = ST_FETCH;
            ST_MEM_WR: begin
                if (bus.mem_ready)  state_nxt = ST_FETCH;
                else if (expire)    state_nxt = ST_HALT;
            end
            ST_BRANCH:    state_nxt = ST_FETCH;
            ST_ADDI_EXEC: state_nxt = ST_ADDI_WB;
            ST_ADDI_WB:   state_nxt = ST_FETCH;
            ST_JUMP:      state_nxt = ST_FETCH;
            ST_HALT:      state_nxt = ST_HALT;
            default:      state_nxt = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ctrl_q      <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            ctrl_q <= decode_state(state_nxt);
            if (expire) begin
                bus_error_q <= 1'b1;   // sticky until reset
            end
        end
    end

    assign bus.pc_write      = ctrl_q.pc_write | (ctrl_q.fetch & bus.mem_ready);
    assign bus.ir_write      = ctrl_q.fetch & bus.mem_ready;
    assign bus.pc_write_cond = ctrl_q.pc_write_cond;
    assign bus.pc_source     = ctrl_q.pc_source;
    assign bus.i_or_d        = ctrl_q.i_or_d;
    assign bus.mem_read      = ctrl_q.mem_read;
    assign bus.mem_write     = ctrl_q.mem_write;
    assign bus.reg_dst       = ctrl_q.reg_dst;
    assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
    assign bus.reg_write     = ctrl_q.reg_write;
    assign bus.alu_src_a     = ctrl_q.alu_src_a;
    assign bus.alu_src_b     = ctrl_q.alu_src_b;
    assign bus.alu_op        = ctrl_q.alu_op;
    assign bus.halted        = ctrl_q.halted;
    assign bus.bus_error     = bus_error_q;
    assign bus.state_o       = state;
endmodule
